// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// MULT_EN adds the S_MDU state used by the multiply/divide unit path.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MULT_EN
    , S_MDU  = 3'd5
`endif
  } state_t;

  typedef enum logic [3:0] {
    ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, NOP, MD, ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b011;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/func to class plus static ALU controls.
// MULT_EN enables MULT/MFHI/MFLO decoding; otherwise they classify as ILLEGAL.
module mc_decode import mc_ctrl_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       ext_op
);

  always_comb begin
    cls     = ILLEGAL;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_NOP:          cls = NOP;
          FN_JR, FN_JALR:  cls = JUMP;
          FN_ADDU: begin cls = ALU_R; alu_op = ALU_ADD; end
          FN_SUBU: begin cls = ALU_R; alu_op = ALU_SUB; end
          FN_OR:   begin cls = ALU_R; alu_op = ALU_OR;  end
          FN_SLT:  begin cls = ALU_R; alu_op = ALU_SLT; end
`ifdef MULT_EN
          FN_MULT, FN_MFHI, FN_MFLO: cls = MD;
`endif
          default: cls = ILLEGAL;
        endcase
      end
      OP_J, OP_JAL:    cls = JUMP;
      // rs - rt drives alu_zero for BEQ; BGTZ relies on the dedicated alu_gtz flag
      OP_BEQ, OP_BGTZ: begin cls = BRANCH; alu_op = ALU_SUB; end
      OP_ADDIU: begin cls = ALU_I; alu_op = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      OP_ORI:   begin cls = ALU_I; alu_op = ALU_OR;  alu_src = 1'b1; end
      OP_LUI:   begin cls = ALU_I; alu_op = ALU_ADD; alu_src = 1'b1; end
      OP_LW, OP_LH: begin cls = LOAD;  alu_src = 1'b1; ext_op = 1'b1; end
      OP_SW:        begin cls = STORE; alu_src = 1'b1; ext_op = 1'b1; end
      default: cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS controller FSM with memory ready handshakes, watchdog and retire counter.
// MULT_EN adds MULT/MFHI/MFLO sequencing with md_start/md_sel outputs.
module mc_controller import mc_ctrl_pkg::*; #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int MDU_LAT     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               alu_zero,
  input  logic               alu_gtz,
  input  logic               instr_ready,
  input  logic               mem_ready,
  output logic               instr_req,
  output logic               ir_write,
  output logic               pc_inc,
  output logic               pc_branch,
  output logic               pc_jump,
  output logic               reg_to_pc,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               write_pc,
  output logic               mem_to_reg,
  output logic               read_half,
  output logic               alu_src,
  output logic               ext_op,
  output logic               ext_result,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_req,
  output logic               mem_write,
  output logic               illegal,
  output logic               bus_err,
  output logic [CNT_W-1:0]   instret,
  output logic [2:0]         state
`ifdef MULT_EN
  ,
  output logic               md_start,
  output logic               md_sel
`endif
);

  // One counter serves both the memory watchdog and the multiply latency.
  localparam int WD_MAX = (MEM_TIMEOUT > MDU_LAT) ? MEM_TIMEOUT : MDU_LAT;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_t          state_q;
  logic [WD_W-1:0] wd;
  iclass_t         cls;
  logic [2:0]      dec_alu_op;
  logic            dec_alu_src;
  logic            dec_ext_op;
  logic            wd_expired;

  mc_decode u_decode (
    .opcode  (opcode),
    .func    (func),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .ext_op  (dec_ext_op)
  );

  assign wd_expired = (wd == WD_LAST);
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wd      <= '0;
      instret <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_ready) begin
            state_q <= S_DECODE;
            wd      <= '0;
          end else if (wd_expired) begin
            wd      <= '0;
          end else begin
            wd      <= wd + 1'b1;
          end
        end
        S_DECODE: begin
          case (cls)
            JUMP, NOP: begin
              state_q <= S_FETCH;
              instret <= instret + CNT_W'(1);
            end
            ILLEGAL: state_q <= S_FETCH;
            default: state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            BRANCH: begin
              state_q <= S_FETCH;
              instret <= instret + CNT_W'(1);
            end
            LOAD, STORE: state_q <= S_MEM;
`ifdef MULT_EN
            MD: state_q <= (func == FN_MULT) ? S_MDU : S_WB;
`endif
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wd <= '0;
            if (cls == STORE) begin
              state_q <= S_FETCH;
              instret <= instret + CNT_W'(1);
            end else begin
              state_q <= S_WB;
            end
          end else if (wd_expired) begin
            state_q <= S_FETCH;
            wd      <= '0;
          end else begin
            wd      <= wd + 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          instret <= instret + CNT_W'(1);
        end
`ifdef MULT_EN
        S_MDU: begin
          if (wd == WD_W'(MDU_LAT - 1)) begin
            state_q <= S_FETCH;
            wd      <= '0;
            instret <= instret + CNT_W'(1);
          end else begin
            wd      <= wd + 1'b1;
          end
        end
`endif
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Enables decode from the registered state; a reset cycle suppresses every enable.
  always_comb begin
    instr_req  = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    pc_jump    = 1'b0;
    reg_to_pc  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    write_pc   = 1'b0;
    mem_to_reg = 1'b0;
    read_half  = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    ext_result = 1'b0;
    alu_op     = '0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
`ifdef MULT_EN
    md_start   = 1'b0;
    md_sel     = 1'b0;
`endif
    if (!reset) begin
      // ALU controls stay stable through MEM/WB so address and result remain valid.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        alu_op  = ALUOP_W'(dec_alu_op);
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
      end
      case (state_q)
        S_FETCH: begin
          instr_req = 1'b1;
          ir_write  = instr_ready;
          pc_inc    = instr_ready;
          bus_err   = !instr_ready && wd_expired;
        end
        S_DECODE: begin
          illegal = (cls == ILLEGAL);
          if (cls == JUMP) begin
            pc_jump = 1'b1;
            if (opcode == OP_JAL) begin
              write_pc  = 1'b1;
              reg_write = 1'b1;
            end
            if (opcode == OP_RTYPE) begin
              reg_to_pc = 1'b1;
              if (func == FN_JALR) begin
                write_pc  = 1'b1;
                reg_write = 1'b1;
                reg_dst   = 1'b1;
              end
            end
          end
        end
        S_EXEC: begin
          if (cls == BRANCH)
            pc_branch = (opcode == OP_BEQ) ? alu_zero : alu_gtz;
`ifdef MULT_EN
          md_start = (cls == MD) && (func == FN_MULT);
`endif
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_write = (cls == STORE);
          bus_err   = !mem_ready && wd_expired;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (cls == ALU_R) || (cls == MD);
          mem_to_reg = (cls == LOAD);
          read_half  = (opcode == OP_LH);
          ext_result = (opcode == OP_LUI);
`ifdef MULT_EN
          md_sel     = (cls == MD) && (func == FN_MFHI);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle MIPS controller. One FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and selects state by state. Instruction and data memory may take a variable number of cycles, handled by ready handshakes with a watchdog. The block sits between the shared datapath (PC, IR, register file, ALU, extender) and the memory ports, and keeps a retired-instruction counter.

## Interface
Parameters:
- ALUOP_W, 3: ALU operation code width. Codes fit in the low 3 bits; upper bits are driven 0.
- MEM_TIMEOUT, 16: maximum cycles to wait for a ready before a bus error (≥1).
- CNT_W, 32: width of the retired-instruction counter.
- MDU_LAT, 4: multiply latency in cycles (used only with MULT_EN, ≥1).

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- func  in  6  IR[5:0].
- alu_zero  in  1  ALU result == 0.
- alu_gtz  in  1  rs > 0 (signed).
- instr_ready  in  1  instruction memory has data.
- mem_ready  in  1  data memory access complete.
- instr_req  out  1  instruction fetch request.
- ir_write, pc_inc, pc_branch, pc_jump, reg_to_pc  out  1 each  PC/IR update enables.
- reg_write, reg_dst, write_pc, mem_to_reg, read_half  out  1 each  register-file controls.
- alu_src, ext_op, ext_result  out  1 each  ALU operand controls.
- alu_op  out  ALUOP_W  ALU operation.
- mem_req, mem_write  out  1 each  data memory request and direction.
- illegal, bus_err  out  1 each  single-cycle error pulses.
- instret  out  CNT_W  count of retired instructions.
- state  out  3  current state, for debug.

## Operation
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, plus S_MDU under MULT_EN.
- S_FETCH
  - Asserts instr_req.
  - When instr_ready is high: pulse ir_write and pc_inc, go to S_DECODE.
- S_DECODE
  - J: pc_jump, then S_FETCH.
  - JAL: pc_jump, write_pc, reg_write, then S_FETCH.
  - JR: pc_jump, reg_to_pc, then S_FETCH.
  - JALR: same as JR plus write_pc, reg_write, reg_dst.
  - NOP: retires, then S_FETCH.
  - Undecoded opcode/func: pulse illegal, then S_FETCH; does not retire.
  - Everything else: S_EXEC.
- S_EXEC drives alu_op, alu_src and ext_op per instruction.
  - BEQ: pc_branch = alu_zero, then S_FETCH.
  - BGTZ: pc_branch = alu_gtz, then S_FETCH.
  - LW, LH, SW: go to S_MEM.
  - ALU-type: go to S_WB.
- S_MEM
  - Holds mem_req, with mem_write for SW, until mem_ready.
  - On mem_ready: SW goes to S_FETCH; LW/LH go to S_WB.
- S_WB
  - reg_write for one cycle.
  - reg_dst for R-type; mem_to_reg for LW/LH; read_half for LH; ext_result for LUI.
  - Then S_FETCH.
- ALU codes: OR=001, ADD=010, SUB=110, SLT=011. LUI uses ADD with ext_result.
- Watchdog: a counter runs while waiting in S_FETCH or S_MEM.
  - If MEM_TIMEOUT cycles elapse with no ready: pulse bus_err, drop the request, go to S_FETCH; the instruction does not retire.
  - In S_FETCH the PC is not advanced; the same address is refetched.
- instret increments by 1 on every transition to S_FETCH from a retiring state. It wraps modulo 2^CNT_W.

## Timing
- Reset: state=S_FETCH, instret=0, watchdog=0. All outputs are 0, except that instr_req is high in the first cycle after reset.
- Outputs are a registered state plus combinational decode; every enable is valid within the cycle of its state.
- Latency with zero-wait memory (ready high on first request cycle):
  - jump: 2 cycles
  - branch: 3 cycles
  - ALU op: 4 cycles
  - SW: 4 cycles
  - LW/LH: 5 cycles
- Each wait cycle adds one. A ready arriving in the same cycle the watchdog expires counts as success.
- Ready inputs are ignored outside their wait states.
- reset mid-instruction wins over every transition; no partial write or retire is issued.

## Configuration
- MULT_EN defined:
  - Decodes MULT (R, func 011000), MFHI (010000) and MFLO (010010).
  - MULT: S_EXEC pulses output md_start, then S_MDU counts MDU_LAT cycles, then S_FETCH (retires).
  - MFHI/MFLO: S_EXEC → S_WB with output md_sel (hi=1) and reg_dst.
- MULT_EN undefined: those encodings raise illegal; md_start and md_sel do not exist.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode/func localparams;
  - ALU-op constants;
  - the instruction-class enum (ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, NOP, MD, ILLEGAL).
- Sub-module mc_decode: purely combinational opcode/func → instruction class plus static ALU controls. The FSM in mc_controller uses the class.

## Test plan
- ADDU, instr_ready/mem_ready tied high → reg_write and reg_dst high in cycle 4, alu_op=010, instret 0→1.
- LW with mem_ready delayed 3 cycles → mem_req held 4 cycles, then S_WB with mem_to_reg=1; total 8 cycles.
- BEQ, alu_zero=1 → pc_branch=1 in S_EXEC. BGTZ with alu_gtz=0 → pc_branch stays 0. Both retire.
- SW, mem_ready never asserted, MEM_TIMEOUT=16 → bus_err pulses at wait cycle 16, state returns to S_FETCH, instret unchanged.
- opcode 6'b111111 → illegal pulses in S_DECODE; with MULT_EN undefined, MULT also raises illegal.
- reset asserted during S_MEM of SW → next cycle state=S_FETCH, mem_req=0, instret=0.
